// File: rtl/basys_keypad_scan_pkg.sv
// Shared types for the keypad scanner: scan FSM states, frame-result encoding and key map.
// The encoding is shared by basys_keypad_scan and keypad_debounce.
package basys_keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_FRAME_END
  } scan_state_t;

  // A frame result is either a 4-bit hex code (bit 4 clear) or KEY_NONE.
  typedef logic [4:0] frame_t;
  localparam frame_t KEY_NONE = 5'h10;

  // Indexed by {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D.
  localparam logic [15:0][3:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  // Lowest pressed row of one column wins; pressed is active-high here.
  function automatic frame_t encode_col(input logic [3:0] pressed, input logic [1:0] col);
    frame_t res;
    res = KEY_NONE;
    for (int unsigned i = 0; i < 4; i++) begin
      if (res == KEY_NONE && pressed[i]) begin
        res = {1'b0, KEY_MAP[{2'(i), col}]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces per-frame keypad results into key_code / key_valid / key_held.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_SCANS frames while held.
module keypad_debounce
  import basys_keypad_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_SCANS = 50
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  frame_t     frame_res_i,
  input  logic       frame_end_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_SCANS);

  frame_t          prev_q;
  frame_t          reported_q;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            key_held_q;
  logic            stable;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_q;
`endif

  always_comb begin
    cnt_d = DB_W'(1);
    if (frame_res_i == prev_q) begin
      cnt_d = (cnt_q == DB_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    stable = (cnt_d == DB_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= KEY_NONE;
      reported_q  <= KEY_NONE;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end_i) begin
        prev_q <= frame_res_i;
        cnt_q  <= cnt_d;
        if (stable) begin
          if (frame_res_i == KEY_NONE) begin
            key_held_q <= 1'b0;
            reported_q <= KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= '0;
`endif
          end else if (frame_res_i != reported_q) begin
            key_code_q  <= frame_res_i[3:0];
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            reported_q  <= frame_res_i;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_q == REP_LAST) begin
            key_valid_q <= 1'b1;
            rep_q       <= '0;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
`endif
        end
      end
    end
  end

  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule

// File: rtl/basys_keypad_scan.sv
// 4x4 Pmod keypad scanner: column drive FSM, row synchroniser, priority encode, debounce.
// Optional auto-repeat in keypad_debounce is enabled by defining KEYPAD_REPEAT_EN.
module basys_keypad_scan
  import basys_keypad_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (SETTLE_CYCLES < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("basys_keypad_scan: parameter out of range");
  end

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_DRIVE = CNT_W'(SETTLE_CYCLES - 2);

  scan_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       col_q;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  frame_t           acc_q;
  frame_t           acc_d;
  frame_t           col_res;

  // Column 0 restarts the frame; later columns only fill in if nothing was found yet.
  always_comb begin
    col_res = encode_col(~sync2_q, col_idx_q);
    acc_d   = acc_q;
    if (col_idx_q == 2'd0 || acc_q == KEY_NONE) begin
      acc_d = col_res;
    end
  end

  // FRAME_END doubles as the first col0 drive cycle, so the frame stays 4*SETTLE_CYCLES long.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      col_idx_q <= '0;
      col_q     <= '1;
      sync1_q   <= '1;
      sync2_q   <= '1;
      acc_q     <= KEY_NONE;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
      unique case (state_q)
        ST_IDLE: begin
          state_q   <= ST_DRIVE;
          cnt_q     <= '0;
          col_idx_q <= '0;
          col_q     <= 4'b1110;
        end
        ST_DRIVE, ST_FRAME_END: begin
          state_q <= (cnt_q == LAST_DRIVE) ? ST_SAMPLE : ST_DRIVE;
          cnt_q   <= cnt_q + 1'b1;
        end
        ST_SAMPLE: begin
          acc_q     <= acc_d;
          cnt_q     <= '0;
          col_idx_q <= col_idx_q + 2'd1;
          col_q     <= {col_q[2:0], col_q[3]};
          state_q   <= (col_idx_q == 2'd3) ? ST_FRAME_END : ST_DRIVE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign col = col_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_SCANS(REPEAT_SCANS)
`endif
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .frame_res_i(acc_q),
    .frame_end_i(state_q == ST_FRAME_END),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .key_held_o (key_held)
  );

endmodule
